video_pattern_checker: RTL and testbench
========================================

Name: video_pattern_checker

Overview:
- Sink-side counterpart to the colour-bar pattern source in the pixel pipeline.
- Consumes the registered pixel stream: timing strobes, syncs, visible flag and 24-bit RGB.
- Checks every visible pixel against the expected 8-stripe, 100% colour-bar sequence, and checks active-line and frame geometry.
- Reports per-frame pass/fail, lock status and saturating error/frame counters.
- Used as a bring-up and self-test monitor ahead of the video DAC/HDMI output stage.

Parameters:
- H_VISIBLE, 640: visible pixels per line.
- V_VISIBLE, 480: lines per frame containing at least one visible pixel.
- STRIPES, 8: stripe count; stripe width = H_VISIBLE/STRIPES, which must divide exactly.
- ERR_CNT_W, 16: error counter width.

Ports:
- clk_i  in  1  pixel clock
- rst_i  in  1  synchronous reset, active-high
- end_of_frame_i  in  1  single-cycle strobe, last cycle of frame
- end_of_line_i  in  1  single-cycle strobe, last cycle of line
- hsync_n_i  in  1  horizontal sync, active-low
- vsync_n_i  in  1  vertical sync, active-low
- visible_i  in  1  rgb_i is an active pixel this cycle
- rgb_i  in  24  pixel as {R,G,B}, 8 bits each
- clear_i  in  1  clears error_count_o, frame_count_o and sync_err_o
- frame_done_o  out  1  one-cycle pulse after each frame is evaluated
- frame_ok_o  out  1  valid with frame_done_o; 1 = frame clean
- locked_o  out  1  last evaluated frame was clean
- error_count_o  out  ERR_CNT_W  mismatching pixels, saturating
- frame_count_o  out  16  evaluated frames, wrapping
- sync_err_o  out  1  sticky sync-during-visible flag (optional feature)

Behaviour:
- Reset values: all outputs 0; state = WAIT_SOF; internal counters 0.
- Expected colour table, index 0..7: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
- pix_cnt counts visible cycles since the last end_of_line_i. stripe = pix_cnt / (H_VISIBLE/STRIPES), implemented as a sub-counter plus a 3-bit index with no divider. Expected value = table[stripe].
- pix_cnt >= H_VISIBLE: pixel counts as a mismatch (overlong line). The stripe index saturates at STRIPES-1; it does not wrap.
- States:
  - WAIT_SOF: ignore all pixels. On end_of_frame_i, go to CHECK and clear the per-frame accumulators.
  - CHECK and LOCKED: check every visible cycle. On end_of_frame_i, evaluate the frame. Clean frame goes to LOCKED; failing frame goes to CHECK.
- Per-line close on end_of_line_i:
  - If pix_cnt (including a pixel in that same cycle) is non-zero and != H_VISIBLE, set the frame's geometry-fail bit.
  - If pix_cnt is non-zero, increment line_cnt.
  - Reset pix_cnt and stripe.
- Simultaneous visible_i and end_of_line_i: the pixel is checked at the current count first, then the line closes.
- Simultaneous end_of_line_i and end_of_frame_i: the line closes first; its result is included in the frame evaluation.
- Frame evaluation:
  - frame_ok = (frame_mismatch == 0) && !geometry_fail && (line_cnt == V_VISIBLE).
  - frame_done_o and frame_ok_o are registered and appear 1 cycle after the end_of_frame_i cycle. locked_o updates in the same cycle.
  - frame_count_o increments (wrapping) in the same cycle.
  - Per-frame accumulators clear for the next frame.
- error_count_o increments by 1 per mismatching pixel in CHECK/LOCKED and saturates at all-ones.
- clear_i takes priority over an increment in the same cycle. clear_i does not change state or locked_o.
- Reset mid-frame: returns to WAIT_SOF. The partial frame is never evaluated and no frame_done_o is issued.
- Synchronous logic only; no combinational path from any input to any output.

Optional Feature:
- Macro VIDEO_PATTERN_CHECK_SYNC_EN.
- Defined:
  - In CHECK/LOCKED, any cycle with visible_i=1 and (hsync_n_i=0 or vsync_n_i=0) sets sticky sync_err_o 1 cycle later.
  - The same condition marks the current frame failed.
  - sync_err_o is cleared only by rst_i or clear_i.
- Not defined: sync_err_o is tied to 0, and syncs do not affect frame_ok.

Test Plan:
- Correct 640x480 bar stream for 2 frames after the initial end_of_frame_i -> frame_done_o pulses twice, frame_ok_o=1 both times, locked_o=1, error_count_o=0, frame_count_o=2.
- Single corruption: pixel 80 of line 10 = FFFFFF instead of FFFF00 -> error_count_o=1, that frame's frame_ok_o=0, locked_o=0; next clean frame sets locked_o=1.
- Line with 639 visible pixels -> geometry fail, frame_ok_o=0, error_count_o unchanged. Line with 641 visible pixels -> error_count_o +1, frame_ok_o=0.
- 479 active lines in a frame -> frame_ok_o=0. end_of_line_i and end_of_frame_i in the same cycle on line 480 -> frame_ok_o=1.
- ERR_CNT_W=4 with 20 bad pixels -> error_count_o holds 15. clear_i coincident with a bad pixel -> error_count_o=0.
- rst_i asserted mid-frame -> all outputs 0, no frame_done_o until one full frame after the next end_of_frame_i. With the macro defined, hsync_n_i=0 during a visible pixel -> sync_err_o=1 and that frame fails.

Source files
------------

// File: rtl/video_pattern_checker.sv
// video_pattern_checker: checks a colour-bar pixel stream for pixel values and line/frame geometry.
// Define VIDEO_PATTERN_CHECK_SYNC_EN to also flag syncs asserted during visible pixels.
module video_pattern_checker #(
    parameter int H_VISIBLE = 640,
    parameter int V_VISIBLE = 480,
    parameter int STRIPES   = 8,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 end_of_frame_i,
    input  logic                 end_of_line_i,
    input  logic                 hsync_n_i,
    input  logic                 vsync_n_i,
    input  logic                 visible_i,
    input  logic [23:0]          rgb_i,
    input  logic                 clear_i,
    output logic                 frame_done_o,
    output logic                 frame_ok_o,
    output logic                 locked_o,
    output logic [ERR_CNT_W-1:0] error_count_o,
    output logic [15:0]          frame_count_o,
    output logic                 sync_err_o
);
    localparam int SW  = H_VISIBLE / STRIPES;
    localparam int PW  = $clog2(H_VISIBLE + 2);
    localparam int LW  = $clog2(V_VISIBLE + 2);
    localparam int SBW = (SW > 1) ? $clog2(SW) : 1;
    localparam logic [2:0] LAST = 3'(STRIPES - 1);
    localparam logic [23:0] BARS [0:7] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                           24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    typedef enum logic [1:0] {WAIT_SOF, CHECK, LOCKED} state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        pix_q, pix_d, pix_now;
    logic [SBW-1:0]       sub_q, sub_d;
    logic [2:0]           stripe_q, stripe_d;
    logic [LW-1:0]        line_q, line_d, line_nx;
    logic                 geo_q, geo_d, geo_nx;
    logic                 fmis_q, fmis_d, fmis_nx;
    logic                 done_q, done_d, ok_q, ok_d, locked_q, locked_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic                 sync_err_q, sync_err_d;
    logic                 active, pix_hit, mism, sync_bad, sub_end, line_has, eval, ok_nx, restart;

`ifdef VIDEO_PATTERN_CHECK_SYNC_EN
    assign sync_bad = pix_hit && (!hsync_n_i || !vsync_n_i);
`else
    logic unused_sync;
    assign unused_sync = hsync_n_i & vsync_n_i;
    assign sync_bad    = 1'b0;
`endif

    always_comb begin
        active   = state_q != WAIT_SOF;
        pix_hit  = active && visible_i;
        restart  = end_of_frame_i;
        eval     = active && end_of_frame_i;
        mism     = pix_hit && (pix_q >= PW'(H_VISIBLE) || rgb_i != BARS[stripe_q]);
        sub_end  = sub_q == SBW'(SW - 1);
        // Pre-close values: a pixel on the closing cycle counts before the line/frame closes.
        pix_now  = pix_hit && pix_q != '1 ? pix_q + 1'b1 : pix_q;
        line_has = end_of_line_i && pix_now != '0;
        line_nx  = line_has && line_q != '1 ? line_q + 1'b1 : line_q;
        geo_nx   = geo_q || (line_has && pix_now != PW'(H_VISIBLE));
        fmis_nx  = fmis_q || mism || sync_bad;
        ok_nx    = !fmis_nx && !geo_nx && line_nx == LW'(V_VISIBLE);
        pix_d    = restart || end_of_line_i ? '0 : pix_now;
        sub_d    = restart || end_of_line_i ? '0 : !pix_hit ? sub_q : sub_end ? '0 : sub_q + 1'b1;
        stripe_d = restart || end_of_line_i ? 3'd0 :
                   pix_hit && sub_end && stripe_q != LAST ? stripe_q + 3'd1 : stripe_q;
        line_d   = restart ? '0 : line_nx;
        geo_d    = !restart && geo_nx;
        fmis_d   = !restart && fmis_nx;
        done_d   = eval;
        ok_d     = eval ? ok_nx : ok_q;
        locked_d = eval ? ok_nx : locked_q;
        state_d  = !end_of_frame_i ? state_q : !active ? CHECK : ok_nx ? LOCKED : CHECK;
        err_d    = clear_i ? '0 : mism && err_q != '1 ? err_q + 1'b1 : err_q;
        frame_cnt_d = clear_i ? '0 : eval ? frame_cnt_q + 16'd1 : frame_cnt_q;
        sync_err_d  = !clear_i && (sync_err_q || sync_bad);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= WAIT_SOF;
            pix_q       <= '0;
            sub_q       <= '0;
            stripe_q    <= 3'd0;
            line_q      <= '0;
            geo_q       <= 1'b0;
            fmis_q      <= 1'b0;
            done_q      <= 1'b0;
            ok_q        <= 1'b0;
            locked_q    <= 1'b0;
            err_q       <= '0;
            frame_cnt_q <= '0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_q       <= pix_d;
            sub_q       <= sub_d;
            stripe_q    <= stripe_d;
            line_q      <= line_d;
            geo_q       <= geo_d;
            fmis_q      <= fmis_d;
            done_q      <= done_d;
            ok_q        <= ok_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign frame_done_o  = done_q;
    assign frame_ok_o    = ok_q;
    assign locked_o      = locked_q;
    assign error_count_o = err_q;
    assign frame_count_o = frame_cnt_q;
    assign sync_err_o    = sync_err_q;
endmodule

// File: tb/tb_video_pattern_checker.sv
// tb_video_pattern_checker: directed scenarios on a 16x4 colour-bar raster with a 4-bit error counter.
module tb_video_pattern_checker;
    localparam int H = 16, V = 4, S = 8, EW = 4, SW = H / S;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1, end_of_frame_i = 1'b0, end_of_line_i = 1'b0;
    logic          hsync_n_i = 1'b1, vsync_n_i = 1'b1, visible_i = 1'b0, clear_i = 1'b0;
    logic [23:0]   rgb_i = '0;
    logic          frame_done_o, frame_ok_o, locked_o, sync_err_o;
    logic [EW-1:0] error_count_o;
    logic [15:0]   frame_count_o;

    int   errors = 0, checks = 0, done_cnt = 0, ok_cnt = 0;
    logic last_ok = 1'b0;
    int   bad_from = -1, bad_n = 0, clr_at = -1, sync_at = -1, gidx = 0;

    always #5 clk = ~clk;

    video_pattern_checker #(.H_VISIBLE(H), .V_VISIBLE(V), .STRIPES(S), .ERR_CNT_W(EW)) dut (
        .clk_i(clk), .rst_i(rst_i), .end_of_frame_i(end_of_frame_i), .end_of_line_i(end_of_line_i),
        .hsync_n_i(hsync_n_i), .vsync_n_i(vsync_n_i), .visible_i(visible_i), .rgb_i(rgb_i),
        .clear_i(clear_i), .frame_done_o(frame_done_o), .frame_ok_o(frame_ok_o), .locked_o(locked_o),
        .error_count_o(error_count_o), .frame_count_o(frame_count_o), .sync_err_o(sync_err_o)
    );

    always @(negedge clk) if (frame_done_o) begin done_cnt++; last_ok = frame_ok_o; if (frame_ok_o) ok_cnt++; end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    function automatic logic [23:0] exp_rgb(input int i);
        int s;
        s = i / SW;
        if (s > S - 1) s = S - 1;
        case (s)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [23:0] c, input logic eol, input logic eof,
                         input logic hs, input logic vs, input logic clr);
        @(negedge clk);
        visible_i = v; rgb_i = c; end_of_line_i = eol; end_of_frame_i = eof;
        hsync_n_i = hs; vsync_n_i = vs; clear_i = clr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 24'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    // Blanking cycles carry low syncs, which must never count as errors.
    task automatic send_line(input int npix, input bit eol_pix, input bit eof_eol);
        for (int i = 0; i < npix; i++) begin
            logic bad, last;
            bad  = bad_from >= 0 && gidx >= bad_from && gidx < bad_from + bad_n;
            last = i == npix - 1;
            drive(1'b1, exp_rgb(i) ^ (bad ? 24'h0000FF : 24'h0), eol_pix && last, eof_eol && eol_pix && last,
                  gidx != sync_at, 1'b1, gidx == clr_at);
            gidx++;
        end
        if (!eol_pix) drive(1'b0, 24'h0, 1'b1, eof_eol, 1'b0, !eof_eol, 1'b0);
    endtask

    task automatic send_frame(input int nlines, input int short_line, input int short_len,
                              input bit eol_pix, input bit coinc);
        gidx = 0;
        for (int l = 0; l < nlines; l++)
            send_line(l == short_line ? short_len : H, eol_pix, coinc && l == nlines - 1);
        if (!coinc) drive(1'b0, 24'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(2);
        bad_from = -1; bad_n = 0; clr_at = -1; sync_at = -1;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        idle(3);
        checks++; if (frame_done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", frame_done_o); end
        checks++; if (frame_ok_o !== 1'b0) begin errors++; $display("FAIL reset_ok: got %b want 0", frame_ok_o); end
        checks++; if (locked_o !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", locked_o); end
        checks++; if (error_count_o !== 4'd0) begin errors++; $display("FAIL reset_err: got %0d want 0", error_count_o); end
        checks++; if (frame_count_o !== 16'd0) begin errors++; $display("FAIL reset_frames: got %0d want 0", frame_count_o); end
        checks++; if (sync_err_o !== 1'b0) begin errors++; $display("FAIL reset_sync: got %b want 0", sync_err_o); end
        rst_i = 1'b0;
        idle(1);
    endtask

    task automatic test_clean;
        gidx = 0; bad_from = 0; bad_n = H;
        send_line(H, 1'b0, 1'b0);
        bad_from = -1; bad_n = 0;
        drive(1'b0, 24'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(2);
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL sof_no_done: got %0d want 0", done_cnt); end
        checks++; if (error_count_o !== 4'd0) begin errors++; $display("FAIL sof_ignored: got %0d want 0", error_count_o); end
        send_frame(V, -1, 0, 1'b0, 1'b0);
        send_frame(V, -1, 0, 1'b0, 1'b0);
        checks++; if (done_cnt !== 2) begin errors++; $display("FAIL clean_done: got %0d want 2", done_cnt); end
        checks++; if (ok_cnt !== 2) begin errors++; $display("FAIL clean_ok: got %0d want 2", ok_cnt); end
        checks++; if (locked_o !== 1'b1) begin errors++; $display("FAIL clean_locked: got %b want 1", locked_o); end
        checks++; if (error_count_o !== 4'd0) begin errors++; $display("FAIL clean_err: got %0d want 0", error_count_o); end
        checks++; if (frame_count_o !== 16'd2) begin errors++; $display("FAIL clean_frames: got %0d want 2", frame_count_o); end
        checks++; if (frame_done_o !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b want 0", frame_done_o); end
    endtask

    task automatic test_corrupt;
        bad_from = H + SW; bad_n = 1;
        send_frame(V, -1, 0, 1'b0, 1'b0);
        checks++; if (error_count_o !== 4'd1) begin errors++; $display("FAIL corrupt_err: got %0d want 1", error_count_o); end
        checks++; if (last_ok !== 1'b0) begin errors++; $display("FAIL corrupt_ok: got %b want 0", last_ok); end
        checks++; if (locked_o !== 1'b0) begin errors++; $display("FAIL corrupt_locked: got %b want 0", locked_o); end
        send_frame(V, -1, 0, 1'b0, 1'b0);
        checks++; if (locked_o !== 1'b1) begin errors++; $display("FAIL relock: got %b want 1", locked_o); end
        checks++; if (frame_count_o !== 16'd4) begin errors++; $display("FAIL corrupt_frames: got %0d want 4", frame_count_o); end
    endtask

    task automatic test_geometry;
        send_frame(V, 2, H - 1, 1'b0, 1'b0);
        checks++; if (last_ok !== 1'b0) begin errors++; $display("FAIL short_ok: got %b want 0", last_ok); end
        checks++; if (error_count_o !== 4'd1) begin errors++; $display("FAIL short_err: got %0d want 1", error_count_o); end
        send_frame(V, 1, H + 1, 1'b0, 1'b0);
        checks++; if (last_ok !== 1'b0) begin errors++; $display("FAIL long_ok: got %b want 0", last_ok); end
        checks++; if (error_count_o !== 4'd2) begin errors++; $display("FAIL long_err: got %0d want 2", error_count_o); end
    endtask

    task automatic test_lines;
        send_frame(V - 1, -1, 0, 1'b0, 1'b0);
        checks++; if (last_ok !== 1'b0) begin errors++; $display("FAIL few_lines_ok: got %b want 0", last_ok); end
        send_frame(V, -1, 0, 1'b0, 1'b1);
        checks++; if (last_ok !== 1'b1) begin errors++; $display("FAIL coinc_ok: got %b want 1", last_ok); end
        send_frame(V, -1, 0, 1'b1, 1'b1);
        checks++; if (last_ok !== 1'b1) begin errors++; $display("FAIL eol_pixel_ok: got %b want 1", last_ok); end
        checks++; if (frame_count_o !== 16'd9) begin errors++; $display("FAIL lines_frames: got %0d want 9", frame_count_o); end
        checks++; if (error_count_o !== 4'd2) begin errors++; $display("FAIL lines_err: got %0d want 2", error_count_o); end
    endtask

    task automatic test_saturate;
        drive(1'b0, 24'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(1);
        checks++; if (error_count_o !== 4'd0) begin errors++; $display("FAIL clear_err: got %0d want 0", error_count_o); end
        checks++; if (locked_o !== 1'b1) begin errors++; $display("FAIL clear_keeps_lock: got %b want 1", locked_o); end
        bad_from = 0; bad_n = 20;
        send_frame(V, -1, 0, 1'b0, 1'b0);
        checks++; if (error_count_o !== 4'd15) begin errors++; $display("FAIL sat_err: got %0d want 15", error_count_o); end
        checks++; if (last_ok !== 1'b0) begin errors++; $display("FAIL sat_ok: got %b want 0", last_ok); end
        bad_from = 5; bad_n = 1; clr_at = 5;
        send_frame(V, -1, 0, 1'b0, 1'b0);
        checks++; if (error_count_o !== 4'd0) begin errors++; $display("FAIL clear_prio_err: got %0d want 0", error_count_o); end
        checks++; if (frame_count_o !== 16'd1) begin errors++; $display("FAIL clear_prio_frames: got %0d want 1", frame_count_o); end
        checks++; if (last_ok !== 1'b0) begin errors++; $display("FAIL clear_prio_ok: got %b want 0", last_ok); end
    endtask

    task automatic test_reset_mid;
        int d0;
        bad_from = 7; bad_n = 1;
        send_frame(V, -1, 0, 1'b0, 1'b0);
        send_frame(V, -1, 0, 1'b0, 1'b0);
        checks++; if (locked_o !== 1'b1) begin errors++; $display("FAIL pre_rst_locked: got %b want 1", locked_o); end
        checks++; if (error_count_o !== 4'd1) begin errors++; $display("FAIL pre_rst_err: got %0d want 1", error_count_o); end
        gidx = 0;
        send_line(H, 1'b0, 1'b0);
        send_line(H, 1'b0, 1'b0);
        rst_i = 1'b1;
        idle(1);
        rst_i = 1'b0;
        checks++; if (locked_o !== 1'b0) begin errors++; $display("FAIL mid_rst_locked: got %b want 0", locked_o); end
        checks++; if (error_count_o !== 4'd0) begin errors++; $display("FAIL mid_rst_err: got %0d want 0", error_count_o); end
        checks++; if (frame_count_o !== 16'd0) begin errors++; $display("FAIL mid_rst_frames: got %0d want 0", frame_count_o); end
        checks++; if (frame_ok_o !== 1'b0) begin errors++; $display("FAIL mid_rst_ok: got %b want 0", frame_ok_o); end
        d0 = done_cnt;
        send_frame(V, -1, 0, 1'b0, 1'b0);
        checks++; if (done_cnt !== d0) begin errors++; $display("FAIL rst_first_eof: got %0d want %0d", done_cnt, d0); end
        send_frame(V, -1, 0, 1'b0, 1'b0);
        checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL rst_next_done: got %0d want %0d", done_cnt, d0 + 1); end
        checks++; if (last_ok !== 1'b1) begin errors++; $display("FAIL rst_next_ok: got %b want 1", last_ok); end
        checks++; if (frame_count_o !== 16'd1) begin errors++; $display("FAIL rst_next_frames: got %0d want 1", frame_count_o); end
    endtask

    task automatic test_sync;
        logic exp_sync, exp_ok;
`ifdef VIDEO_PATTERN_CHECK_SYNC_EN
        exp_sync = 1'b1; exp_ok = 1'b0;
`else
        exp_sync = 1'b0; exp_ok = 1'b1;
`endif
        sync_at = 3;
        send_frame(V, -1, 0, 1'b0, 1'b0);
        checks++; if (sync_err_o !== exp_sync) begin errors++; $display("FAIL sync_err: got %b want %b", sync_err_o, exp_sync); end
        checks++; if (last_ok !== exp_ok) begin errors++; $display("FAIL sync_ok: got %b want %b", last_ok, exp_ok); end
        checks++; if (error_count_o !== 4'd0) begin errors++; $display("FAIL sync_pix_err: got %0d want 0", error_count_o); end
        send_frame(V, -1, 0, 1'b0, 1'b0);
        checks++; if (sync_err_o !== exp_sync) begin errors++; $display("FAIL sync_sticky: got %b want %b", sync_err_o, exp_sync); end
        checks++; if (locked_o !== 1'b1) begin errors++; $display("FAIL sync_relock: got %b want 1", locked_o); end
        drive(1'b0, 24'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(1);
        checks++; if (sync_err_o !== 1'b0) begin errors++; $display("FAIL sync_clear: got %b want 0", sync_err_o); end
        checks++; if (frame_count_o !== 16'd0) begin errors++; $display("FAIL sync_clear_frames: got %0d want 0", frame_count_o); end
    endtask

    initial begin
        test_reset;
        test_clean;
        test_corrupt;
        test_geometry;
        test_lines;
        test_saturate;
        test_reset_mid;
        test_sync;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
